// File: rtl/opc_intctl.sv
// opc_intctl - prioritised interrupt controller with vectored requests.
//
// Collects NCH active-low interrupt sources, latches them as pending
// (falling-edge or level per channel), and requests the CPU for the
// lowest-numbered eligible channel. Nesting is controlled by an in-service
// register (ISR). While a channel is in service, only lower-numbered channels
// can interrupt it. The CPU takes a vector with ack. It ends service with an
// EOI write.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous, active-high
//   clken    - state-update enable (reset still acts when low)
//   int_b    - asynchronous active-low interrupt sources [NCH]
//   sel/rnw  - register-port select and read(1)/write(0)
//   regaddr  - 0=MASK, 1=PEND (W1C), 2=ISR (write = EOI), 3=VBASE
//   din/dout - register write / combinational read data
//   ack      - CPU vector-taken pulse
//   irq_b    - registered active-low request to the CPU
//   vector   - registered handler address, VBASE + id*VSTRIDE while requesting
//
// AW is expected to be at most 32, so VBASE fits the 32-bit data port.
module opc_intctl #(
  parameter int             NCH       = 4,
  parameter int             AW        = 20,
  parameter logic [NCH-1:0] EDGE_MASK = '1,
  parameter int             VSTRIDE   = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic [NCH-1:0] int_b,
  input  logic           sel,
  input  logic           rnw,
  input  logic [1:0]     regaddr,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  input  logic           ack,
  output logic           irq_b,
  output logic [AW-1:0]  vector
);

  localparam int             IW        = $clog2(NCH);
  localparam logic [AW-1:0]  STRIDE_AW = AW'(VSTRIDE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Registered state
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] prev_q, prev_d;
  logic [NCH-1:0] pend_edge_q, pend_edge_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] isr_q, isr_d;
  logic [AW-1:0]  vbase_q, vbase_d;
  state_t         state_q, state_d;
  logic [IW-1:0]  id_q, id_d;
  logic           irq_b_q, irq_b_d;
  logic [AW-1:0]  vector_q, vector_d;

  // Combinational helpers
  logic [NCH-1:0] pend;
  logic [NCH-1:0] isr_lowest;
  logic [NCH-1:0] below_isr;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] edge_fell;
  logic [NCH-1:0] id_onehot;
  logic [IW-1:0]  winner;
  logic           any_elig;
  logic           wr_en;
  logic           ack_take;
  logic           din_unused;

  assign din_unused = ^din;
  assign irq_b      = irq_b_q;
  assign vector     = vector_q;

  // Pending view and eligibility. Level channels report the inverted
  // synchronised input directly. Edge channels report their latched bit.
  // isr_lowest isolates the lowest set ISR bit. Subtracting one from it gives
  // the channels that may still nest. This is all ones when ISR is empty.
  always_comb begin
    pend       = (pend_edge_q & EDGE_MASK) | (~sync2_q & ~EDGE_MASK);
    isr_lowest = isr_q & (~isr_q + NCH'(1));
    below_isr  = isr_lowest - NCH'(1);
    eligible   = pend & mask_q & below_isr;
    any_elig   = |eligible;
    winner     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IW'(i);
    end
    edge_fell  = prev_q & ~sync2_q & EDGE_MASK;
    id_onehot  = NCH'(1) << id_q;
    wr_en      = sel & ~rnw;
    ack_take   = (state_q == ST_REQ) && ack;
  end

  // Next-state for synchronisers and the register file. Ack and W1C both
  // clear a pending edge first. A same-cycle edge then sets it again, so a
  // fresh edge is never lost. EOI removes the old lowest ISR bit before ack
  // records the newly taken channel.
  always_comb begin
    sync1_d     = int_b;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;

    pend_edge_d = pend_edge_q;
    if (wr_en && regaddr == 2'd1) pend_edge_d = pend_edge_d & ~din[NCH-1:0];
    if (ack_take)                 pend_edge_d = pend_edge_d & ~id_onehot;
    pend_edge_d = (pend_edge_d | edge_fell) & EDGE_MASK;

    isr_d = isr_q;
    if (wr_en && regaddr == 2'd2) isr_d = isr_q & ~isr_lowest;
    if (ack_take)                 isr_d = isr_d | id_onehot;

    mask_d  = mask_q;
    if (wr_en && regaddr == 2'd0) mask_d = din[NCH-1:0];

    vbase_d = vbase_q;
    if (wr_en && regaddr == 2'd3) vbase_d = din[AW-1:0];
  end

  // Request FSM. The winning id is frozen for the whole request, even if a
  // higher-priority channel becomes eligible. Ack ends the request. So does
  // the latched channel losing eligibility, but ack wins if both happen.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    irq_b_d  = irq_b_q;
    vector_d = vector_q;
    if (state_q == ST_IDLE) begin
      if (any_elig) begin
        state_d  = ST_REQ;
        id_d     = winner;
        irq_b_d  = 1'b0;
        vector_d = vbase_q + AW'(winner) * STRIDE_AW;
      end else begin
        irq_b_d  = 1'b1;
        vector_d = '0;
      end
    end else begin
      if (ack || !eligible[id_q]) begin
        state_d  = ST_IDLE;
        irq_b_d  = 1'b1;
        vector_d = '0;
      end else begin
        vector_d = vbase_q + AW'(id_q) * STRIDE_AW;
      end
    end
  end

  // Register update. Reset acts regardless of clken. Otherwise everything
  // holds while clken is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      pend_edge_q <= '0;
      mask_q      <= '0;
      isr_q       <= '0;
      vbase_q     <= '0;
      state_q     <= ST_IDLE;
      id_q        <= '0;
      irq_b_q     <= 1'b1;
      vector_q    <= '0;
    end else if (clken) begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pend_edge_q <= pend_edge_d;
      mask_q      <= mask_d;
      isr_q       <= isr_d;
      vbase_q     <= vbase_d;
      state_q     <= state_d;
      id_q        <= id_d;
      irq_b_q     <= irq_b_d;
      vector_q    <= vector_d;
    end
  end

  // Register read port. It is combinational and has no side effects.
  always_comb begin
    dout = '0;
    if (sel && rnw) begin
      case (regaddr)
        2'd0:    dout = 32'(mask_q);
        2'd1:    dout = 32'(pend);
        2'd2:    dout = 32'(isr_q);
        default: dout = 32'(vbase_q);
      endcase
    end
  end

endmodule

// File: tb/tb_opc_intctl.sv
// tb_opc_intctl - self-checking bench for opc_intctl.
// The first tests are directed scenarios with hand-derived expectations.
// A randomized run follows. It is compared cycle by cycle against a
// channel-level reference model.
// The DUT uses NCH=4 and AW=20. Channel 0 is level-sensitive and
// channels 1..3 are falling-edge latched.
module tb_opc_intctl;

  localparam int             NCH       = 4;
  localparam int             AW        = 20;
  localparam int             VSTRIDE   = 2;
  localparam logic [NCH-1:0] EDGE_MASK = 4'b1110;

  logic           clk;
  logic           reset;
  logic           clken;
  logic [NCH-1:0] int_b;
  logic           sel;
  logic           rnw;
  logic [1:0]     regaddr;
  logic [31:0]    din;
  logic [31:0]    dout;
  logic           ack;
  logic           irq_b;
  logic [AW-1:0]  vector;

  int checks = 0;
  int errors = 0;

  opc_intctl #(
    .NCH(NCH), .AW(AW), .EDGE_MASK(EDGE_MASK), .VSTRIDE(VSTRIDE)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .int_b(int_b),
    .sel(sel), .rnw(rnw), .regaddr(regaddr), .din(din), .dout(dout),
    .ack(ack), .irq_b(irq_b), .vector(vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the randomized run
  logic [NCH-1:0] m_s1, m_s2, m_prev, m_pend, m_mask, m_isr;
  logic [AW-1:0]  m_vbase, m_vec;
  logic           m_irq, m_busy;
  int             m_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel = 1'b0; rnw = 1'b1; regaddr = 2'd0; din = '0; ack = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; rnw = 1'b0; regaddr = a; din = d;
    tick();
    sel = 1'b0; rnw = 1'b1; din = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; rnw = 1'b1; regaddr = a;
    #1;
    v = dout;
    sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; clken = 1'b1; int_b = '1; idle_inputs();
    tick(); tick();
    reset = 1'b0;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_irq_b: got %b expected 1", irq_b); end
    checks++; if (vector !== '0) begin errors++; $display("[TB] FAIL reset_vector: got %h expected 0", vector); end
    reg_read(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask: got %h expected 0", v); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_pend: got %h expected 0", v); end
    reg_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_isr: got %h expected 0", v); end
    reg_read(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_vbase: got %h expected 0", v); end
  endtask

  task automatic test_basic_edge();
    logic [31:0] v;
    reg_write(2'd0, 32'hF);
    reg_write(2'd3, 32'h100);
    int_b[2] = 1'b0;
    repeat (3) tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency_early: got %b expected 1", irq_b); end
    tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h104) begin errors++; $display("[TB] FAIL basic_vector: got %h expected 104", vector); end
    int_b[2] = 1'b1;
    reg_read(2'd1, v);
    checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL basic_pend: got %h expected 4", v); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL basic_ack_irq: got %b expected 1", irq_b); end
    reg_read(2'd2, v);
    checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL basic_isr: got %h expected 4", v); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL basic_pend_clear: got %h expected 0", v); end
    reg_write(2'd2, 32'hDEAD);
    reg_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL basic_eoi: got %h expected 0", v); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    int_b = 4'b0101;
    repeat (4) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL simul_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h102) begin errors++; $display("[TB] FAIL simul_vector_ch1: got %h expected 102", vector); end
    int_b = '1;
    ack = 1'b1; tick(); ack = 1'b0;
    reg_read(2'd2, v);
    checks++; if (v !== 32'h2) begin errors++; $display("[TB] FAIL simul_isr: got %h expected 2", v); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL simul_pend_ch3: got %h expected 8", v); end
    repeat (3) tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL simul_blocked: got %b expected 1", irq_b); end
    reg_write(2'd2, 32'h0);
    tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL simul_ch3_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h106) begin errors++; $display("[TB] FAIL simul_vector_ch3: got %h expected 106", vector); end
    ack = 1'b1; tick(); ack = 1'b0;
    reg_read(2'd2, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL simul_isr_ch3: got %h expected 8", v); end
    reg_write(2'd2, 32'h0);
  endtask

  task automatic test_nested();
    logic [31:0] v;
    int_b[2] = 1'b0;
    repeat (4) tick();
    checks++; if (vector !== 20'h104) begin errors++; $display("[TB] FAIL nest_vector_ch2: got %h expected 104", vector); end
    int_b = '1;
    ack = 1'b1; tick(); ack = 1'b0;
    int_b[0] = 1'b0;
    repeat (3) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL nest_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h100) begin errors++; $display("[TB] FAIL nest_vector_ch0: got %h expected 100", vector); end
    ack = 1'b1; tick(); ack = 1'b0;
    reg_read(2'd2, v);
    checks++; if (v !== 32'h5) begin errors++; $display("[TB] FAIL nest_isr: got %h expected 5", v); end
    int_b[0] = 1'b1;
    repeat (3) tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL nest_idle: got %b expected 1", irq_b); end
    reg_write(2'd2, 32'h0);
    reg_read(2'd2, v);
    checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL nest_eoi: got %h expected 4", v); end
    reg_write(2'd2, 32'h0);
    reg_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL nest_eoi2: got %h expected 0", v); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    int_b[0] = 1'b0;
    repeat (3) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL level_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h100) begin errors++; $display("[TB] FAIL level_vector: got %h expected 100", vector); end
    reg_write(2'd1, 32'h1);
    reg_read(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL level_w1c_ignored: got %h expected 1", v); end
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL level_still_req: got %b expected 0", irq_b); end
    int_b[0] = 1'b1;
    repeat (2) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL level_release_early: got %b expected 0", irq_b); end
    tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL level_release: got %b expected 1", irq_b); end
    reg_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL level_isr: got %h expected 0", v); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL level_pend: got %h expected 0", v); end
  endtask

  task automatic test_clken();
    logic [31:0] v;
    int_b[3] = 1'b0;
    repeat (2) tick();
    clken = 1'b0;
    reg_write(2'd0, 32'h0);
    repeat (4) tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL clken_frozen_irq: got %b expected 1", irq_b); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL clken_frozen_pend: got %h expected 0", v); end
    reg_read(2'd0, v);
    checks++; if (v !== 32'hF) begin errors++; $display("[TB] FAIL clken_frozen_mask: got %h expected F", v); end
    clken = 1'b1;
    tick();
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL clken_resume_irq: got %b expected 1", irq_b); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL clken_resume_pend: got %h expected 8", v); end
    tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL clken_req_irq: got %b expected 0", irq_b); end
    checks++; if (vector !== 20'h106) begin errors++; $display("[TB] FAIL clken_req_vector: got %h expected 106", vector); end
    int_b = '1;
    clken = 1'b0; ack = 1'b1;
    repeat (2) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL clken_ack_frozen: got %b expected 0", irq_b); end
    clken = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL clken_ack_irq: got %b expected 1", irq_b); end
    reg_read(2'd2, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL clken_ack_isr: got %h expected 8", v); end
    reg_write(2'd2, 32'h0);
  endtask

  task automatic test_conflicts();
    logic [31:0] v;
    reg_write(2'd0, 32'h0);
    int_b[3] = 1'b0;
    repeat (2) tick();
    reg_write(2'd1, 32'h8);
    reg_read(2'd1, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL conf_set_beats_w1c: got %h expected 8", v); end
    int_b = '1;
    reg_write(2'd1, 32'h8);
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL conf_w1c: got %h expected 0", v); end
    reg_write(2'd0, 32'hF);
    int_b[2] = 1'b0;
    repeat (4) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL conf_req_ch2: got %b expected 0", irq_b); end
    int_b = '1;
    sel = 1'b1; rnw = 1'b0; regaddr = 2'd1; din = 32'h4; ack = 1'b1;
    tick();
    idle_inputs();
    reg_read(2'd2, v);
    checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL conf_ack_w1c_isr: got %h expected 4", v); end
    reg_read(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL conf_ack_w1c_pend: got %h expected 0", v); end
    int_b[1] = 1'b0;
    repeat (4) tick();
    checks++; if (vector !== 20'h102) begin errors++; $display("[TB] FAIL conf_req_ch1: got %h expected 102", vector); end
    int_b = '1;
    sel = 1'b1; rnw = 1'b0; regaddr = 2'd2; ack = 1'b1;
    tick();
    idle_inputs();
    reg_read(2'd2, v);
    checks++; if (v !== 32'h2) begin errors++; $display("[TB] FAIL conf_ack_eoi_isr: got %h expected 2", v); end
    reg_write(2'd2, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int_b[1] = 1'b0;
    repeat (4) tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req: got %b expected 0", irq_b); end
    reset = 1'b1; tick(); reset = 1'b0;
    int_b = '1;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_irq: got %b expected 1", irq_b); end
    checks++; if (vector !== '0) begin errors++; $display("[TB] FAIL rstmid_vector: got %h expected 0", vector); end
    reg_read(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_mask: got %h expected 0", v); end
    reg_read(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_vbase: got %h expected 0", v); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ack_irq: got %b expected 1", irq_b); end
    reg_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_ack_isr: got %h expected 0", v); end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_prev = '1;
    m_pend = '0; m_mask = '0; m_isr = '0; m_vbase = '0;
    m_busy = 1'b0; m_id = 0; m_irq = 1'b1; m_vec = '0;
  endtask

  function automatic logic [NCH-1:0] model_pend_view();
    logic [NCH-1:0] p;
    for (int i = 0; i < NCH; i++) p[i] = EDGE_MASK[i] ? m_pend[i] : !m_s2[i];
    return p;
  endfunction

  function automatic logic [31:0] model_read();
    if (!(sel && rnw)) return 32'h0;
    case (regaddr)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(model_pend_view());
      2'd2:    return 32'(m_isr);
      default: return 32'(m_vbase);
    endcase
  endfunction

  // One enabled clock of the reference: decide from the pre-edge values,
  // then commit everything together.
  task automatic model_step();
    logic [NCH-1:0] p, el, npend, nisr;
    int  low_isr, win;
    bit  take;
    if (reset) begin model_reset(); return; end
    if (!clken) return;
    low_isr = NCH;
    for (int i = NCH - 1; i >= 0; i--) if (m_isr[i]) low_isr = i;
    p = model_pend_view();
    for (int i = 0; i < NCH; i++) el[i] = p[i] && m_mask[i] && (i < low_isr);
    win = -1;
    for (int i = NCH - 1; i >= 0; i--) if (el[i]) win = i;
    take = m_busy && ack;
    nisr = m_isr;
    if (sel && !rnw && regaddr == 2'd2 && low_isr < NCH) nisr[low_isr] = 1'b0;
    if (take) nisr[m_id] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      npend[i] = 1'b0;
      if (EDGE_MASK[i]) begin
        npend[i] = m_pend[i];
        if (sel && !rnw && regaddr == 2'd1 && din[i]) npend[i] = 1'b0;
        if (take && i == m_id) npend[i] = 1'b0;
        if (m_prev[i] && !m_s2[i]) npend[i] = 1'b1;
      end
    end
    if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1'b1; m_id = win; m_irq = 1'b0; m_vec = AW'(int'(m_vbase) + win * VSTRIDE);
      end else begin
        m_irq = 1'b1; m_vec = '0;
      end
    end else if (ack || !el[m_id]) begin
      m_busy = 1'b0; m_irq = 1'b1; m_vec = '0;
    end else begin
      m_vec = AW'(int'(m_vbase) + m_id * VSTRIDE);
    end
    m_isr = nisr;
    m_pend = npend;
    if (sel && !rnw && regaddr == 2'd0) m_mask = din[NCH-1:0];
    if (sel && !rnw && regaddr == 2'd3) m_vbase = din[AW-1:0];
    m_prev = m_s2; m_s2 = m_s1; m_s1 = int_b;
  endtask

  task automatic test_random();
    logic [31:0] exp_dout;
    reset = 1'b1; clken = 1'b1; int_b = '1; idle_inputs();
    tick();
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      clken = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 7) == 0) int_b[i] = ~int_b[i];
      sel = ($urandom_range(0, 3) == 0);
      rnw = 1'($urandom_range(0, 1));
      regaddr = 2'($urandom_range(0, 3));
      din = $urandom();
      ack = (irq_b == 1'b0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      #1;
      exp_dout = model_read();
      checks++; if (dout !== exp_dout) begin errors++; $display("[TB] FAIL rand_dout cyc %0d: got %h expected %h", cyc, dout, exp_dout); end
      @(posedge clk);
      model_step();
      #1;
      checks++; if (irq_b !== m_irq) begin errors++; $display("[TB] FAIL rand_irq_b cyc %0d: got %b expected %b", cyc, irq_b, m_irq); end
      checks++; if (vector !== m_vec) begin errors++; $display("[TB] FAIL rand_vector cyc %0d: got %h expected %h", cyc, vector, m_vec); end
    end
    reset = 1'b0; clken = 1'b1; idle_inputs();
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; int_b = '1;
    idle_inputs();
    test_reset();
    test_basic_edge();
    test_simultaneous();
    test_nested();
    test_level();
    test_clken();
    test_conflicts();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
